// File: rtl/digitube_pkg.sv
// Shared helpers for the digit-tube scan-to-static latch: width math,
// blank pattern and per-digit slice indexing.
package digitube_pkg;

  // Largest pattern width supported; narrower uses take the low bits.
  localparam logic [63:0] SEG_BLANK = '1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
      r++;
    end
    return r;
  endfunction

  // Bits needed to hold 0..maxv, never less than one.
  function automatic int unsigned width_for(input int unsigned maxv);
    int unsigned w;
    w = clog2(maxv + 1);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/digitube_stable.sv
// Input stability filter: flags when the sampled bus has stayed unchanged
// for STABLE_CYC further edges after it first appeared.
module digitube_stable
  import digitube_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic         stable_c
);

  localparam int unsigned       CNT_W   = width_for(STABLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_THR = CNT_W'(STABLE_CYC - 1);

  logic [W-1:0]     in_q;
  logic [CNT_W-1:0] stab_cnt;
  logic             same_c;

  assign same_c   = (din == in_q);
  assign stable_c = same_c && (stab_cnt >= CNT_THR);

  // Saturating run-length counter; any change restarts filtering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_q     <= '0;
      stab_cnt <= '0;
    end else begin
      in_q <= din;
      if (!same_c) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digitube_latch.sv
// Scan-to-static digit-tube latch: holds each digit's segment pattern between
// scan visits, with glitch filtering, refresh timeout and multi-hot detection.
module digitube_latch
  import digitube_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SEG_W      = 8,
  parameter bit          AN_ACT_LOW = 1'b0,
  parameter int unsigned STABLE_CYC = 2,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS-1:0]         scan_an,
  input  logic [SEG_W-1:0]          scan_seg,
  input  logic                      err_clr,
  output logic [DIGITS*SEG_W-1:0]   digi_out,
  output logic [DIGITS-1:0]         digi_valid,
  output logic                      err_multi
);

  localparam int unsigned       AGE_W   = width_for(TIMEOUT);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(TIMEOUT);
  localparam logic [SEG_W-1:0]  BLANK   = SEG_W'(SEG_BLANK);

  logic [DIGITS-1:0] an;
  logic              stable_c;
  logic              an_one_c;
  logic              an_multi_c;

  assign an = AN_ACT_LOW ? ~scan_an : scan_an;

  digitube_stable #(
    .W          (DIGITS + SEG_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_stable (
    .clk      (clk),
    .reset    (reset),
    .din      ({an, scan_seg}),
    .stable_c (stable_c)
  );

  assign an_one_c   = (an != '0) && ((an & (an - DIGITS'(1))) == '0);
  assign an_multi_c = (an != '0) && !an_one_c;

  // Sticky multi-hot flag; a fresh multi-hot sample beats a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_multi <= 1'b0;
    end else if (stable_c && an_multi_c) begin
      err_multi <= 1'b1;
    end else if (err_clr) begin
      err_multi <= 1'b0;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [SEG_W-1:0] seg_q;
    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_nxt_c;
    logic             valid_q;
    logic             wr_c;

    assign wr_c      = stable_c && an_one_c && an[i];
    assign age_nxt_c = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);

    // Write restarts the age; otherwise age saturates and blanks at TIMEOUT.
    always_ff @(posedge clk) begin
      if (!reset) begin
        seg_q   <= BLANK;
        age_q   <= AGE_MAX;
        valid_q <= 1'b0;
      end else if (wr_c) begin
        seg_q   <= scan_seg;
        age_q   <= '0;
        valid_q <= 1'b1;
      end else if (TIMEOUT != 0) begin
        age_q <= age_nxt_c;
        if (age_nxt_c == AGE_MAX) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign digi_valid[i]                         = valid_q;
    assign digi_out[slice_lo(i, SEG_W) +: SEG_W] = valid_q ? seg_q : BLANK;
  end

endmodule

// File: tb/tb_digitube_latch.sv
// Directed bench for digitube_latch: one active-high-anode instance with a
// short timeout and one active-low-anode instance with the default timeout.
module tb_digitube_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  scan_an;
  logic [7:0]  scan_seg;
  logic        err_clr;

  logic [31:0] out_a, out_b;
  logic [3:0]  valid_a, valid_b;
  logic        err_a, err_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  digitube_latch #(
    .DIGITS(4), .SEG_W(8), .AN_ACT_LOW(1'b0), .STABLE_CYC(2), .TIMEOUT(10)
  ) u_dut (
    .clk(clk), .reset(reset), .scan_an(scan_an), .scan_seg(scan_seg),
    .err_clr(err_clr), .digi_out(out_a), .digi_valid(valid_a), .err_multi(err_a)
  );

  digitube_latch #(
    .DIGITS(4), .SEG_W(8), .AN_ACT_LOW(1'b1), .STABLE_CYC(2), .TIMEOUT(1000)
  ) u_low (
    .clk(clk), .reset(reset), .scan_an(~scan_an), .scan_seg(scan_seg),
    .err_clr(err_clr), .digi_out(out_b), .digi_valid(valid_b), .err_multi(err_b)
  );

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        clr;
    logic [31:0] out;
    logic [3:0]  valid;
    logic        err;
    logic        chk_low;
  } vec_t;

  vec_t tbl [18];

  task automatic cyc(input logic [3:0] an, input logic [7:0] seg, input logic clr);
    scan_an  = an;
    scan_seg = seg;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit low, input logic [31:0] eo,
                     input logic [3:0] ev, input logic ee);
    logic [36:0] act;
    logic [36:0] exp;
    exp = {eo, ev, ee};
    act = low ? {out_b, valid_b, err_b} : {out_a, valid_a, err_a};
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s (%s): got out=%h valid=%b err=%b, want out=%h valid=%b err=%b",
               name, low ? "an_low" : "an_high", act[36:5], act[4:1], act[0], eo, ev, ee);
    end
  endtask

  task automatic chk_both(input string name, input logic [31:0] eo,
                          input logic [3:0] ev, input logic ee);
    chk(name, 1'b0, eo, ev, ee);
    chk(name, 1'b1, eo, ev, ee);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(4'b0001, 8'h00, 1'b0);
    cyc(4'b0001, 8'h00, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0]  segs [4];
    logic [31:0] eo;
    logic [3:0]  ev;

    // basic latch, glitch reject, multi-hot and clear behaviour
    tbl[0]  = '{4'b0010, 8'hC0, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{4'b0010, 8'hC0, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{4'b0010, 8'hC0, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[3]  = '{4'b0100, 8'hF9, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[4]  = '{4'b0100, 8'hF9, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[5]  = '{4'b0000, 8'hF9, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[6]  = '{4'b0000, 8'hF9, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 8'hF9, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[8]  = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[9]  = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b0, 1'b1};
    tbl[10] = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b1, 1'b1};
    tbl[11] = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_C0FF, 4'b0010, 1'b1, 1'b1};
    // digit 1 was last written at row 2, so it times out here on the short-timeout unit
    tbl[12] = '{4'b0000, 8'hFF, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{4'b0011, 8'h55, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0};
    tbl[16] = '{4'b0011, 8'h55, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0};
    tbl[17] = '{4'b0000, 8'hFF, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0};

    segs[0] = 8'hA4; segs[1] = 8'hB0; segs[2] = 8'h99; segs[3] = 8'h92;

    // reset held with a live anode
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0001, 8'h00, 1'b0);
      chk_both("reset_hold", 32'hFFFF_FFFF, 4'b0000, 1'b0);
    end
    reset = 1'b1;

    for (int r = 0; r < 18; r++) begin
      cyc(tbl[r].an, tbl[r].seg, tbl[r].clr);
      chk($sformatf("vec%0d", r), 1'b0, tbl[r].out, tbl[r].valid, tbl[r].err);
      if (tbl[r].chk_low) begin
        chk($sformatf("vec%0d", r), 1'b1, tbl[r].out, tbl[r].valid, tbl[r].err);
      end
    end

    // full scan, four cycles per slot, checked on the active-low unit
    do_reset();
    eo = 32'hFFFF_FFFF;
    ev = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(4'(1 << k), segs[k], 1'b0);
      end
      eo[k*8 +: 8] = segs[k];
      ev[k]        = 1'b1;
      chk($sformatf("scan_slot%0d", k), 1'b1, eo, ev, 1'b0);
    end

    // timeout: valid falls exactly ten edges after the last write
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0001, 8'h80, 1'b0);
    chk("to_write", 1'b0, 32'hFFFF_FF80, 4'b0001, 1'b0);
    for (int c = 0; c < 9; c++) cyc(4'b0000, 8'hFF, 1'b0);
    chk("to_edge9", 1'b0, 32'hFFFF_FF80, 4'b0001, 1'b0);
    cyc(4'b0000, 8'hFF, 1'b0);
    chk("to_edge10", 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0);

    // rewrite landing on the timeout edge keeps the digit valid
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0001, 8'h80, 1'b0);
    for (int c = 0; c < 7; c++) cyc(4'b0000, 8'hFF, 1'b0);
    cyc(4'b0001, 8'h86, 1'b0);
    cyc(4'b0001, 8'h86, 1'b0);
    chk("rw_edge9", 1'b0, 32'hFFFF_FF80, 4'b0001, 1'b0);
    cyc(4'b0001, 8'h86, 1'b0);
    chk("rw_edge10", 1'b0, 32'hFFFF_FF86, 4'b0001, 1'b0);
    cyc(4'b0000, 8'hFF, 1'b0);
    chk("rw_edge11", 1'b0, 32'hFFFF_FF86, 4'b0001, 1'b0);

    // reset on the edge that would have written discards the write
    do_reset();
    cyc(4'b0001, 8'h80, 1'b0);
    cyc(4'b0001, 8'h80, 1'b0);
    reset = 1'b0;
    cyc(4'b0001, 8'h80, 1'b0);
    chk_both("mid_reset", 32'hFFFF_FFFF, 4'b0000, 1'b0);
    reset = 1'b1;
    cyc(4'b0001, 8'h80, 1'b0);
    chk_both("post_reset_e0", 32'hFFFF_FFFF, 4'b0000, 1'b0);
    cyc(4'b0001, 8'h80, 1'b0);
    chk_both("post_reset_e1", 32'hFFFF_FFFF, 4'b0000, 1'b0);
    cyc(4'b0001, 8'h80, 1'b0);
    chk_both("post_reset_e2", 32'hFFFF_FF80, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
